if_fetch_stage: RTL and testbench

IF stage, directly downstream of the pre-IF stage. Latches the PC/exception bundle issued to the ICache and waits for the ICache data return. Holds the returned instruction while ID stalls, then presents {exception, PC, instruction} to ID. On flush it drops in-flight ICache returns so stale instructions never reach ID.

---
 rtl/if_fetch_stage_if.sv | 29 ++
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 tb/tb_if_fetch_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Handshake and bundle signals between pre-IF, ICache, IF and ID.
// The fetch stage binds to the slave modport; its environment binds to master.
interface if_fetch_stage_if #(
   parameter int PS_TO_FS_BUS_WD = 39,
   parameter int FS_TO_DS_BUS_WD = 70
);
   logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus;
   logic                       ps_to_fs_valid;
   logic                       fs_allowin;
   logic [31:0]                icache_rdata;
   logic                       icache_data_ok;
   logic                       ds_allowin;
   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
   logic                       flush;
   logic                       br_flush;

   modport slave (
      input  ps_to_fs_bus, ps_to_fs_valid, icache_rdata, icache_data_ok,
             ds_allowin, flush, br_flush,
      output fs_allowin, fs_to_ds_valid, fs_to_ds_bus
   );

   modport master (
      output ps_to_fs_bus, ps_to_fs_valid, icache_rdata, icache_data_ok,
             ds_allowin, flush, br_flush,
      input  fs_allowin, fs_to_ds_valid, fs_to_ds_bus
   );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: latches the pre-IF PC bundle, waits for ICache data, holds it for ID.
// Optional macro FS_PERF_CNT_EN adds fs_stall_cnt (cycles spent in WAIT/DISCARD).
module if_fetch_stage #(
   parameter int PS_TO_FS_BUS_WD = 39,
   parameter int FS_TO_DS_BUS_WD = 70
) (
   input  logic                 clk,
   input  logic                 reset,
   if_fetch_stage_if.slave      fs_if
`ifdef FS_PERF_CNT_EN
   ,
   output logic [31:0]          fs_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_READY   = 2'd2,
      S_DISCARD = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        ex_q, ex_d;
   logic [4:0]  exctype_q, exctype_d;
   logic [31:0] inst_q, inst_d;

   logic [PS_TO_FS_BUS_WD-1:0] ps_bus;
   logic                       in_inst_valid;
   logic [31:0]                in_pc;
   logic                       in_ex;
   logic [4:0]                 in_exctype;
   logic                       any_flush;
   logic                       allowin;
   logic                       accept;

   assign ps_bus        = fs_if.ps_to_fs_bus;
   assign in_inst_valid = ps_bus[38];
   assign in_pc         = ps_bus[37:6];
   assign in_ex         = ps_bus[5];
   assign in_exctype    = ps_bus[4:0];

   assign any_flush = fs_if.flush | fs_if.br_flush;
   assign allowin   = (state_q == S_IDLE) | ((state_q == S_READY) & fs_if.ds_allowin);
   // Bundles carrying neither an instruction fetch nor an exception are dropped here.
   assign accept    = fs_if.ps_to_fs_valid & allowin & ~any_flush & (in_inst_valid | in_ex);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ex_d      = ex_q;
      exctype_d = exctype_q;
      inst_d    = inst_q;

      case (state_q)
         S_IDLE, S_READY: begin
            if (accept) begin
               pc_d      = in_pc;
               ex_d      = in_ex;
               exctype_d = in_exctype;
               inst_d    = 32'h0;
               state_d   = in_ex ? S_READY : S_WAIT;
            end else if (state_q == S_READY && (any_flush || fs_if.ds_allowin)) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (fs_if.icache_data_ok) begin
               if (any_flush) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_READY;
                  inst_d  = fs_if.icache_rdata;
               end
            end else if (any_flush) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (fs_if.icache_data_ok) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= 32'h0;
         ex_q      <= 1'b0;
         exctype_q <= 5'h0;
         inst_q    <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ex_q      <= ex_d;
         exctype_q <= exctype_d;
         inst_q    <= inst_d;
      end
   end

   logic [FS_TO_DS_BUS_WD-1:0] ds_bus;
   assign ds_bus = {ex_q, exctype_q, pc_q, inst_q};

   assign fs_if.fs_allowin     = allowin;
   assign fs_if.fs_to_ds_valid = (state_q == S_READY);
   assign fs_if.fs_to_ds_bus   = ds_bus;

`ifdef FS_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'h0;
      end else if (state_q == S_WAIT || state_q == S_DISCARD) begin
         stall_cnt_q <= stall_cnt_q + 32'h1;
      end
   end

   assign fs_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed vector table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   if_fetch_stage_if #(.PS_TO_FS_BUS_WD(39), .FS_TO_DS_BUS_WD(70)) bus_if ();

`ifdef FS_PERF_CNT_EN
   logic [31:0] fs_stall_cnt;
   if_fetch_stage dut (.clk(clk), .reset(reset), .fs_if(bus_if.slave), .fs_stall_cnt(fs_stall_cnt));
`else
   if_fetch_stage dut (.clk(clk), .reset(reset), .fs_if(bus_if.slave));
`endif

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      logic        pv;
      logic [38:0] pbus;
      logic        dok;
      logic [31:0] rdata;
      logic        ds;
      logic        fl;
      logic        bfl;
      logic        ev;
      logic        ea;
      logic [69:0] ebus;
   } vec_t;

   vec_t tbl[34];

   function automatic logic [38:0] mkps(logic iv, logic [31:0] pc, logic ex, logic [4:0] exc);
      return {iv, pc, ex, exc};
   endfunction

   function automatic logic [69:0] mkds(logic ex, logic [4:0] exc, logic [31:0] pc, logic [31:0] inst);
      return {ex, exc, pc, inst};
   endfunction

   function automatic vec_t v(logic pv, logic [38:0] pbus, logic dok, logic [31:0] rdata,
                              logic ds, logic fl, logic bfl, logic ev, logic ea, logic [69:0] ebus);
      vec_t r;
      r.pv = pv; r.pbus = pbus; r.dok = dok; r.rdata = rdata; r.ds = ds;
      r.fl = fl; r.bfl = bfl; r.ev = ev; r.ea = ea; r.ebus = ebus;
      return r;
   endfunction

   task automatic chk(string nm, logic [69:0] act, logic [69:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic pv, logic [38:0] pbus, logic dok, logic [31:0] rdata,
                        logic ds, logic fl, logic bfl);
      bus_if.ps_to_fs_valid = pv;
      bus_if.ps_to_fs_bus   = pbus;
      bus_if.icache_data_ok = dok;
      bus_if.icache_rdata   = rdata;
      bus_if.ds_allowin     = ds;
      bus_if.flush          = fl;
      bus_if.br_flush       = bfl;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, '0, 0, '0, 1, 0, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Reference model: an outstanding-request flag, a drop-next-return flag and a held bundle.
   bit          m_out, m_drop, m_held;
   logic [69:0] m_bus;

   task automatic model_step(logic pv, logic [38:0] pbus, logic dok, logic [31:0] rdata,
                             logic ds, logic fl_any);
      bit allow, acc;
      allow = !m_out && (!m_held || ds);
      acc   = pv && allow && !fl_any && (pbus[38] || pbus[5]);
      if (m_out) begin
         if (dok) begin
            if (!m_drop && !fl_any) begin
               m_held = 1;
               m_bus[31:0] = rdata;
            end
            m_out  = 0;
            m_drop = 0;
         end else if (fl_any) begin
            m_drop = 1;
         end
      end else begin
         if (m_held && (ds || fl_any)) m_held = 0;
         if (acc) begin
            m_bus = mkds(pbus[5], pbus[4:0], pbus[37:6], 32'h0);
            if (pbus[5]) m_held = 1;
            else begin
               m_out  = 1;
               m_drop = 0;
            end
         end
      end
   endtask

   initial begin
      logic [38:0] p0, p1, p4, p8, pe, pa, pb, pz, px, pf;
      p0 = mkps(1, 32'hBFC00000, 0, 5'd0);
      p4 = mkps(1, 32'hBFC00004, 0, 5'd0);
      pe = mkps(0, 32'hBFC00002, 1, 5'd4);
      p8 = mkps(1, 32'hBFC00008, 0, 5'd0);
      pa = mkps(1, 32'h00000100, 0, 5'd0);
      pb = mkps(1, 32'h00000104, 0, 5'd0);
      pz = mkps(0, 32'h00000200, 0, 5'd0);
      px = mkps(0, 32'h00000300, 1, 5'd5);
      pf = mkps(1, 32'h00000400, 0, 5'd0);
      p1 = '0;

      //             pv pbus dok rdata          ds fl bfl ev ea ebus
      tbl[0]  = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[1]  = v(1, p0, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[2]  = v(0, p1, 1, 32'h24020001,   1, 0, 0, 0, 0, '0);
      tbl[3]  = v(0, p1, 0, 32'h0,          1, 0, 0, 1, 1, mkds(0, 0, 32'hBFC00000, 32'h24020001));
      tbl[4]  = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[5]  = v(1, p0, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[6]  = v(0, p1, 1, 32'h24020001,   0, 0, 0, 0, 0, '0);
      tbl[7]  = v(0, p1, 0, 32'h0,          0, 0, 0, 1, 0, mkds(0, 0, 32'hBFC00000, 32'h24020001));
      tbl[8]  = v(0, p1, 0, 32'h0,          0, 0, 0, 1, 0, mkds(0, 0, 32'hBFC00000, 32'h24020001));
      tbl[9]  = v(0, p1, 0, 32'h0,          0, 0, 0, 1, 0, mkds(0, 0, 32'hBFC00000, 32'h24020001));
      tbl[10] = v(0, p1, 0, 32'h0,          1, 0, 0, 1, 1, mkds(0, 0, 32'hBFC00000, 32'h24020001));
      tbl[11] = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[12] = v(1, p4, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[13] = v(0, p1, 0, 32'h0,          1, 1, 0, 0, 0, '0);
      tbl[14] = v(0, p1, 1, 32'hDEADBEEF,   1, 0, 0, 0, 0, '0);
      tbl[15] = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[16] = v(1, pe, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[17] = v(0, p1, 0, 32'h0,          1, 0, 0, 1, 1, mkds(1, 5'd4, 32'hBFC00002, 32'h0));
      tbl[18] = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[19] = v(1, p8, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[20] = v(0, p1, 1, 32'h11111111,   1, 0, 1, 0, 0, '0);
      tbl[21] = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[22] = v(1, pa, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[23] = v(0, p1, 1, 32'hAAAA0001,   1, 0, 0, 0, 0, '0);
      tbl[24] = v(1, pb, 0, 32'h0,          1, 0, 0, 1, 1, mkds(0, 0, 32'h100, 32'hAAAA0001));
      tbl[25] = v(0, p1, 1, 32'hAAAA0002,   1, 0, 0, 0, 0, '0);
      tbl[26] = v(0, p1, 0, 32'h0,          1, 0, 0, 1, 1, mkds(0, 0, 32'h104, 32'hAAAA0002));
      tbl[27] = v(1, pz, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[28] = v(0, p1, 1, 32'h00000055,   1, 0, 0, 0, 1, '0);
      tbl[29] = v(1, px, 0, 32'h0,          1, 0, 0, 0, 1, '0);
      tbl[30] = v(0, p1, 1, 32'h00000077,   0, 0, 0, 1, 0, mkds(1, 5'd5, 32'h300, 32'h0));
      tbl[31] = v(0, p1, 0, 32'h0,          1, 0, 0, 1, 1, mkds(1, 5'd5, 32'h300, 32'h0));
      tbl[32] = v(1, pf, 0, 32'h0,          1, 1, 0, 0, 1, '0);
      tbl[33] = v(0, p1, 0, 32'h0,          1, 0, 0, 0, 1, '0);

      reset = 1'b1;
      drive(0, '0, 0, '0, 1, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", 70'(bus_if.fs_to_ds_valid), 70'(0));
      chk("reset_allowin", 70'(bus_if.fs_allowin), 70'(1));
      chk("reset_bus", bus_if.fs_to_ds_bus, '0);
`ifdef FS_PERF_CNT_EN
      chk("reset_cnt", 70'(fs_stall_cnt), 70'(0));
`endif
      reset = 1'b0;

      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         drive(tbl[i].pv, tbl[i].pbus, tbl[i].dok, tbl[i].rdata, tbl[i].ds, tbl[i].fl, tbl[i].bfl);
         #1;
         chk($sformatf("tbl%0d_valid", i), 70'(bus_if.fs_to_ds_valid), 70'(tbl[i].ev));
         chk($sformatf("tbl%0d_allowin", i), 70'(bus_if.fs_allowin), 70'(tbl[i].ea));
         if (tbl[i].ev) chk($sformatf("tbl%0d_bus", i), bus_if.fs_to_ds_bus, tbl[i].ebus);
      end

      // Reset while a request is outstanding returns to an empty stage.
      @(negedge clk);
      drive(1, p0, 0, '0, 1, 0, 0);
      @(negedge clk);
      drive(0, '0, 0, '0, 1, 0, 0);
      #1;
      chk("midwait_allowin", 70'(bus_if.fs_allowin), 70'(0));
      do_reset();
      #1;
      chk("post_reset_valid", 70'(bus_if.fs_to_ds_valid), 70'(0));
      chk("post_reset_allowin", 70'(bus_if.fs_allowin), 70'(1));

`ifdef FS_PERF_CNT_EN
      chk("cnt_after_reset", 70'(fs_stall_cnt), 70'(0));
      @(negedge clk);
      drive(1, p0, 0, '0, 1, 0, 0);
      repeat (4) begin
         @(negedge clk);
         drive(0, '0, 0, '0, 1, 0, 0);
      end
      @(negedge clk);
      drive(0, '0, 1, 32'h12345678, 1, 0, 0);
      @(negedge clk);
      drive(0, '0, 0, '0, 1, 0, 0);
      #1;
      chk("stall_cnt_5", 70'(fs_stall_cnt), 70'(5));
      chk("stall_valid", 70'(bus_if.fs_to_ds_valid), 70'(1));
`endif

      // Randomized traffic against the reference model.
      do_reset();
      m_out = 0; m_drop = 0; m_held = 0; m_bus = '0;
      for (int c = 0; c < 400; c++) begin
         logic pv, dok, ds, fl, bfl;
         logic [38:0] pbus;
         logic [31:0] rd;
         pv   = ($urandom_range(0, 1) == 1);
         pbus = {($urandom_range(0, 3) != 0), 32'($urandom), ($urandom_range(0, 4) == 0), 5'($urandom)};
         dok  = ($urandom_range(0, 9) < 4);
         rd   = $urandom;
         ds   = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 19) == 0);
         bfl  = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         drive(pv, pbus, dok, rd, ds, fl, bfl);
         #1;
         chk("rnd_valid", 70'(bus_if.fs_to_ds_valid), 70'(m_held));
         chk("rnd_allowin", 70'(bus_if.fs_allowin), 70'(!m_out && (!m_held || ds)));
         if (m_held) chk("rnd_bus", bus_if.fs_to_ds_bus, m_bus);
         model_step(pv, pbus, dok, rd, ds, fl | bfl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
